// File: rtl/tkx_pkg.sv
// Shared types and constants for the tweakey load controller.
package tkx_pkg;

    localparam int unsigned TKX_WORD_W = 32;
    localparam int unsigned TKX_WORDS  = 4;
    localparam int unsigned TKX_CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } tkx_state_e;

    // True when the beat counter sits on the final word slot.
    function automatic logic tkx_last_slot(input logic [TKX_CNT_W-1:0] cnt);
        return cnt == TKX_CNT_W'(TKX_WORDS - 1);
    endfunction

endpackage

// File: rtl/tkx_load_ctrl.sv
// Streams a 128-bit tweakey, 32 bits per shift, into the tweakey register's shift chain.
// Optional zero padding of short tweakeys is enabled by defining TKX_LOAD_PAD_EN.
module tkx_load_ctrl
    import tkx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TKX_WORD_W-1:0] pdi_data,
    input  logic                  pdi_valid,
    input  logic                  pdi_last,
    output logic                  pdi_ready,
    output logic [TKX_WORD_W-1:0] sdi,
    output logic                  se,
    output logic                  busy,
    output logic                  done
);

    tkx_state_e           state_q, state_d;
    logic [TKX_CNT_W-1:0] cnt_q, cnt_d;
    logic                 in_load;
    logic                 beat;
    logic                 shift;
    logic                 pad_active;

`ifdef TKX_LOAD_PAD_EN
    logic pad_q, pad_d;
    assign pad_active = pad_q;
`else
    logic unused_pdi_last;
    assign unused_pdi_last = pdi_last;
    assign pad_active      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef TKX_LOAD_PAD_EN
            pad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef TKX_LOAD_PAD_EN
            pad_q   <= pad_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef TKX_LOAD_PAD_EN
        pad_d   = pad_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (shift) begin
                    cnt_d = cnt_q + TKX_CNT_W'(1);
                    if (tkx_last_slot(cnt_q)) begin
                        state_d = DONE;
`ifdef TKX_LOAD_PAD_EN
                        pad_d   = 1'b0;
`endif
                    end
`ifdef TKX_LOAD_PAD_EN
                    else if (beat && pdi_last) begin
                        pad_d = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, whatever state_q holds.
    always_comb begin
        in_load   = (state_q == LOAD) && !rst;
        pdi_ready = in_load && !pad_active;
        beat      = pdi_valid && pdi_ready;
        shift     = beat || (in_load && pad_active);
        se        = shift;
        sdi       = beat ? pdi_data : '0;
        busy      = !rst && (state_q != IDLE);
        done      = !rst && (state_q == DONE);
    end

endmodule

// File: tb/tb_tkx_load_ctrl.sv
// Directed bench for tkx_load_ctrl with an sdi scoreboard and a model shift chain.
module tb_tkx_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pdi_data;
    logic        pdi_valid;
    logic        pdi_last;
    logic        pdi_ready;
    logic [31:0] sdi;
    logic        se;
    logic        busy;
    logic        done;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc_n = 0;
    int          se_cnt = 0;
    int          done_cnt = 0;
    logic [127:0] tkx = '0;
    logic [31:0] exp_q[$];

    tkx_load_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pdi_data (pdi_data),
        .pdi_valid(pdi_valid),
        .pdi_last (pdi_last),
        .pdi_ready(pdi_ready),
        .sdi      (sdi),
        .se       (se),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Scoreboard: every shift must match the next queued word; idle cycles must drive zero.
    always @(negedge clk) begin
        logic [31:0] e;
        if (se === 1'b1) begin
            se_cnt++;
            if (exp_q.size() == 0) begin
                check("se_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sdi", sdi, e);
            end
            tkx = {tkx[95:0], sdi};
        end else begin
            check("sdi_idle", sdi, 0);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic do_load(input logic [127:0] blk, input int gap, input bit poke,
                           output int lat);
        int t0;
        tkx      = '0;
        se_cnt   = 0;
        done_cnt = 0;
        start    = 1'b1;
        samp();
        check("idle_busy", busy, 0);
        check("idle_ready", pdi_ready, 0);
        t0 = cyc_n;
        step();
        start = poke;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                for (int g = 0; g < gap; g++) begin
                    pdi_valid = 1'b0;
                    pdi_data  = 32'hFFFF_FFFF;
                    samp();
                    check("stall_se", se, 0);
                    check("stall_ready", pdi_ready, 1);
                    check("stall_busy", busy, 1);
                    step();
                end
            end
            pdi_valid = 1'b1;
            pdi_data  = blk[127-32*i -: 32];
            exp_q.push_back(pdi_data);
            samp();
            check("beat_se", se, 1);
            check("beat_busy", busy, 1);
            check("beat_done", done, 0);
            step();
        end
        pdi_valid = 1'b0;
        samp();
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_se", se, 0);
        lat = cyc_n - t0;
        step();
        start = 1'b0;
        samp();
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        step();
        check("tkx", tkx, blk);
        check("se_count", se_cnt, 4);
        check("done_count", done_cnt, 1);
        check("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int lat_base;
        int lat_stall;
        int lat_poke;
        rst       = 1'b1;
        start     = 1'b0;
        pdi_data  = '0;
        pdi_valid = 1'b0;
        pdi_last  = 1'b0;

        // Reset state, then the cycle after reset
        samp();
        check("rst_ready", pdi_ready, 0);
        check("rst_se", se, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        step();
        step();
        rst = 1'b0;
        samp();
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", pdi_ready, 0);
        check("post_rst_done", done, 0);
        step();

        // Full load without stalls: 1 IDLE cycle + 4 beats before DONE
        do_load(128'h00010203_04050607_08090A0B_0C0D0E0F, 0, 1'b0, lat_base);
        check("lat_base", lat_base, 5);

        // Stall of 3 cycles between words 2 and 3 delays DONE by the gap length
        do_load(128'h00010203_04050607_08090A0B_0C0D0E0F, 3, 1'b0, lat_stall);
        check("lat_stall", lat_stall, lat_base + 3);

        // start held high through LOAD and DONE must not restart anything
        do_load(128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C, 0, 1'b1, lat_poke);
        check("lat_poke", lat_poke, lat_base);

        // Reset after the second word abandons the load
        tkx   = '0;
        start = 1'b1;
        samp();
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pdi_valid = 1'b1;
            pdi_data  = 32'h5500_0000 + 32'(i);
            exp_q.push_back(pdi_data);
            samp();
            check("pre_rst_se", se, 1);
            step();
        end
        rst      = 1'b1;
        pdi_data = 32'hAAAA_AAAA;
        samp();
        check("midrst_se", se, 0);
        check("midrst_ready", pdi_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            samp();
            check("after_rst_busy", busy, 0);
            check("after_rst_se", se, 0);
            check("after_rst_ready", pdi_ready, 0);
            step();
        end
        pdi_valid = 1'b0;
        check("rst_sb_empty", exp_q.size(), 0);
        do_load(128'h11111111_22222222_33333333_44444444, 0, 1'b0, lat_base);
        check("lat_after_rst", lat_base, 5);

        // Short tweakey: one word flagged as last
        tkx      = '0;
        se_cnt   = 0;
        done_cnt = 0;
        start    = 1'b1;
        samp();
        step();
        start     = 1'b0;
        pdi_valid = 1'b1;
        pdi_last  = 1'b1;
        pdi_data  = 32'hDEAD_BEEF;
        exp_q.push_back(pdi_data);
        samp();
        check("pad_first_se", se, 1);
        check("pad_first_ready", pdi_ready, 1);
        step();
        pdi_last = 1'b0;
`ifdef TKX_LOAD_PAD_EN
        pdi_data = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h0);
            samp();
            check("pad_se", se, 1);
            check("pad_ready", pdi_ready, 0);
            check("pad_busy", busy, 1);
            step();
        end
        pdi_valid = 1'b0;
        samp();
        check("pad_done", done, 1);
        step();
        samp();
        check("pad_post_busy", busy, 0);
        step();
        check("pad_tkx", tkx, 128'hDEADBEEF_00000000_00000000_00000000);
`else
        pdi_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            samp();
            check("nopad_ready", pdi_ready, 1);
            check("nopad_se", se, 0);
            check("nopad_done", done, 0);
            step();
        end
        for (int i = 1; i < 4; i++) begin
            pdi_valid = 1'b1;
            pdi_data  = 32'h1111_1111 * 32'(i);
            exp_q.push_back(pdi_data);
            samp();
            check("nopad_beat_se", se, 1);
            step();
        end
        pdi_valid = 1'b0;
        samp();
        check("nopad_done_pulse", done, 1);
        step();
        samp();
        check("nopad_post_busy", busy, 0);
        step();
        check("nopad_tkx", tkx, 128'hDEADBEEF_11111111_22222222_33333333);
`endif
        check("pad_se_count", se_cnt, 4);
        check("pad_done_count", done_cnt, 1);
        check("pad_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
